delta_controller_input_loader: RTL and testbench
================================================

Name: delta_controller_input_loader

Overview:
- Upstream counterpart of the Delta controller output extractor.
- Streams an input feature map from DRAM as 32-bit words, packs every four words into one 128-bit line, and writes the lines sequentially into the Input SRAM that feeds the PU array.
- Driven by the Delta controller: `start` begins a load, `finished` acknowledges completion.

Parameters:
- DRAM_W, 32, DRAM data width (bits).
- LINE_W, 128, SRAM line width; always 4*DRAM_W (8 elements of 16 bits).
- ADDR_W, 32, DRAM and SRAM address width.
- CH_W, 10, width of IC_Num.
- SIZE_W, 8, width of IRC_Size.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  load request; sampled only in IDLE.
- IC_Num  in  CH_W  input channel count.
- IRC_Size  in  SIZE_W  feature map rows = cols.
- input_start_address  in  ADDR_W  DRAM byte address of first word.
- DRAM_Read  out  1  read request; held until DRAM_ReadDone.
- DRAM_Address  out  ADDR_W  DRAM byte address.
- DRAM_ReadData  in  DRAM_W  read data, valid with DRAM_ReadDone.
- DRAM_ReadDone  in  1  read completion strobe.
- Input_SRAM_w_d  out  LINE_W  packed line.
- Input_SRAM_w_addr  out  ADDR_W  SRAM element address.
- Input_SRAM_w_en  out  1  write request; held until Input_SRAM_w_done.
- Input_SRAM_w_done  in  1  write completion strobe.
- busy  out  1  high in every state except IDLE.
- finished  out  1  one-cycle done pulse.

Behaviour:
- **Reset** (reset low, async): all outputs and registers clear to 0 and state returns to IDLE. A reset mid-load abandons the load; no partial-line write is issued afterwards.
- **Start** (IDLE with start=1):
  - Latch IC_Num, IRC_Size and input_start_address.
  - Compute LPR = ceil(IRC_Size/8) (lines per row).
  - Clear counters ch, r, cl (line within row), w (word 0..3), the DRAM word count and the SRAM address.
  - Go to CHECK.
- **start outside IDLE** is ignored. Config inputs are don't-care after the start cycle.
- **States:** IDLE, CHECK, RD, WINC, WR, LINC, FINISH.
  - CHECK:
    - If ch==IC_Num, or latched IC_Num==0, or IRC_Size==0 -> FINISH.
    - Else -> RD.
  - RD:
    - DRAM_Read=1; DRAM_Address = start_addr + 4*word_count (ADDR_W wrap).
    - On DRAM_ReadDone: capture DRAM_ReadData into line bits [32w+31:32w], word_count++, -> WINC.
    - Without ReadDone: stay in RD with outputs stable.
  - WINC:
    - DRAM_Read=0 (one idle cycle between reads).
    - If w==3: w=0, -> WR. Else: w++, -> RD.
  - WR:
    - Input_SRAM_w_en=1; w_d = packed line; w_addr = SRAM address counter.
    - On Input_SRAM_w_done -> LINC. Without w_done: hold w_en, w_d and w_addr stable.
  - LINC:
    - SRAM address += 8.
    - Advance counters: cl wraps at LPR-1 -> r++; r wraps at IRC_Size-1 -> ch++.
    - -> CHECK.
  - FINISH: finished=1 for exactly one cycle, -> IDLE.
- **Padded rows:** DRAM holds rows padded to a multiple of 8 elements, so the last line of a row is still 4 words (no partial reads).
- **Totals:** lines = IC_Num * IRC_Size * LPR; words = 4*lines.
- **Best-case timing** (ReadDone and w_done returned the same cycle they are requested): 11 cycles per line (CHECK + 4*(RD+WINC) + WR + LINC).
- **Strobe timing:** an early DRAM_ReadDone or w_done outside RD/WR is ignored.
- **Packed line register:** holds its value after a write; it is not cleared between lines.

Test Plan:
- **8x8, 1 channel:** reset, IC_Num=1, IRC_Size=8, addr=0x1000, immediate done strobes, start pulse at cycle 0.
  - 32 reads at 0x1000..0x107C step 4.
  - 8 writes at SRAM addr 0,8,...,56.
  - finished high only at cycle 90; busy low after.
- **Word packing:** ReadData = 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> first w_d = 0x44444444_33333333_22222222_11111111.
- **Padded rows and stalls:** IC_Num=2, IRC_Size=10, ReadDone delayed 3 cycles, w_done delayed 2 cycles.
  - LPR=2; exactly 40 writes and 160 reads; last DRAM_Address = base+636.
  - Outputs stable during every stall.
- **Zero-size load:** IRC_Size=0 or IC_Num=0 -> no DRAM_Read or w_en; finished pulses 2 cycles after start.
- **Reset mid-load:** drive reset low during a WR stall -> w_en, DRAM_Read and busy drop immediately.
  - A new start then restarts at input_start_address with SRAM addr 0.
- **start while busy:** pulse start mid-load -> ignored; the single load completes with one finished pulse.

Source files
------------

// File: rtl/delta_controller_input_loader.sv
//------------------------------------------------------------------------------
// delta_controller_input_loader
//
// Purpose:
//   Streams an input feature map out of DRAM as DRAM_W-bit words, packs every
//   four consecutive words into one LINE_W-bit line (word 0 in the low bits)
//   and writes the lines sequentially into the Input SRAM that feeds the PU
//   array. A load walks channels (ch), rows (r) and lines within a row (cl);
//   rows in DRAM are padded to a multiple of 8 elements, so every line is
//   always exactly four words.
//
// Ports:
//   clock / reset              rising-edge clock, asynchronous active-low reset
//   start                      load request, only sampled while idle
//   IC_Num, IRC_Size           channel count and square feature-map size
//   input_start_address        DRAM byte address of the first word
//   DRAM_Read / DRAM_Address   read request (held until DRAM_ReadDone) + address
//   DRAM_ReadData/ReadDone     read data, valid together with the done strobe
//   Input_SRAM_w_d/_w_addr     packed line and SRAM element address
//   Input_SRAM_w_en / _w_done  write request (held until done) + done strobe
//   busy                       high whenever the loader is not idle
//   finished                   one-cycle pulse when a load has completed
//------------------------------------------------------------------------------
module delta_controller_input_loader #(
   parameter int DRAM_W = 32,
   parameter int LINE_W = 128,
   parameter int ADDR_W = 32,
   parameter int CH_W   = 10,
   parameter int SIZE_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [CH_W-1:0]   IC_Num,
   input  logic [SIZE_W-1:0] IRC_Size,
   input  logic [ADDR_W-1:0] input_start_address,
   output logic              DRAM_Read,
   output logic [ADDR_W-1:0] DRAM_Address,
   input  logic [DRAM_W-1:0] DRAM_ReadData,
   input  logic              DRAM_ReadDone,
   output logic [LINE_W-1:0] Input_SRAM_w_d,
   output logic [ADDR_W-1:0] Input_SRAM_w_addr,
   output logic              Input_SRAM_w_en,
   input  logic              Input_SRAM_w_done,
   output logic              busy,
   output logic              finished
);

   // Lines per row needs at most SIZE_W-2 bits: ceil((2^SIZE_W - 1) / 8).
   localparam int LPR_W = SIZE_W - 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_RD     = 3'd2,
      ST_WINC   = 3'd3,
      ST_WR     = 3'd4,
      ST_LINC   = 3'd5,
      ST_FINISH = 3'd6
   } state_t;

   state_t              r_state;
   state_t              w_next_state;

   // Latched configuration
   logic [CH_W-1:0]     r_ic_num;
   logic [SIZE_W-1:0]   r_size;
   logic [ADDR_W-1:0]   r_start_addr;
   logic [LPR_W-1:0]    r_lpr;

   // Traversal counters
   logic [CH_W-1:0]     r_ch;
   logic [SIZE_W-1:0]   r_r;
   logic [LPR_W-1:0]    r_cl;
   logic [1:0]          r_w;
   logic [ADDR_W-1:0]   r_word_cnt;
   logic [ADDR_W-1:0]   r_sram_addr;

   // Line being assembled; intentionally never cleared between lines
   logic [LINE_W-1:0]   r_line;

   // Registered outputs
   logic                r_dram_read;
   logic [ADDR_W-1:0]   r_dram_addr;
   logic                r_sram_w_en;
   logic                r_busy;
   logic                r_finished;

   // Combinational helpers
   logic [SIZE_W:0]     w_size_plus7;
   logic [LPR_W-1:0]    w_lpr_calc;
   logic [ADDR_W-1:0]   w_rd_addr;
   logic                w_load_empty;
   logic                w_cl_last;
   logic                w_r_last;

   // ceil(IRC_Size / 8) computed on the raw input, captured on start
   assign w_size_plus7 = {1'b0, IRC_Size} + (SIZE_W + 1)'(7);
   assign w_lpr_calc   = w_size_plus7[SIZE_W:3];

   // Byte address of the next word: base + 4 * words already read (wraps)
   assign w_rd_addr    = r_start_addr + {r_word_cnt[ADDR_W-3:0], 2'b00};

   // Load is complete once all channels are done, or it was empty to begin with
   assign w_load_empty = (r_ch == r_ic_num) ||
                         (r_ic_num == {CH_W{1'b0}}) ||
                         (r_size == {SIZE_W{1'b0}});

   // Wrap points of the line-in-row and row counters; only used in LINC,
   // where r_lpr and r_size are known to be non-zero
   assign w_cl_last    = (r_cl == (r_lpr - LPR_W'(1)));
   assign w_r_last     = (r_r == (r_size - SIZE_W'(1)));

   // Drive ports from their registers
   assign DRAM_Read         = r_dram_read;
   assign DRAM_Address      = r_dram_addr;
   assign Input_SRAM_w_en   = r_sram_w_en;
   assign Input_SRAM_w_d    = r_line;
   assign Input_SRAM_w_addr = r_sram_addr;
   assign busy              = r_busy;
   assign finished          = r_finished;

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next_state = ST_CHECK;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_CHECK: begin
            if (w_load_empty) begin
               w_next_state = ST_FINISH;
            end else begin
               w_next_state = ST_RD;
            end
         end
         ST_RD: begin
            if (DRAM_ReadDone) begin
               w_next_state = ST_WINC;
            end else begin
               w_next_state = ST_RD;
            end
         end
         ST_WINC: begin
            if (r_w == 2'd3) begin
               w_next_state = ST_WR;
            end else begin
               w_next_state = ST_RD;
            end
         end
         ST_WR: begin
            if (Input_SRAM_w_done) begin
               w_next_state = ST_LINC;
            end else begin
               w_next_state = ST_WR;
            end
         end
         ST_LINC: begin
            w_next_state = ST_CHECK;
         end
         ST_FINISH: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Output registers, decoded from the state being entered so that each
   // output is valid for exactly the cycles spent in the matching state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_dram_read <= 1'b0;
         r_dram_addr <= {ADDR_W{1'b0}};
         r_sram_w_en <= 1'b0;
         r_busy      <= 1'b0;
         r_finished  <= 1'b0;
      end else begin
         r_dram_read <= (w_next_state == ST_RD);
         r_sram_w_en <= (w_next_state == ST_WR);
         r_busy      <= (w_next_state != ST_IDLE);
         r_finished  <= (w_next_state == ST_FINISH);
         // Word count only moves on leaving RD, so the address is stable
         // for the whole time a read is outstanding
         if (w_next_state == ST_RD) begin
            r_dram_addr <= w_rd_addr;
         end else begin
            r_dram_addr <= r_dram_addr;
         end
      end
   end

   // Configuration latch on start
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ic_num     <= {CH_W{1'b0}};
         r_size       <= {SIZE_W{1'b0}};
         r_start_addr <= {ADDR_W{1'b0}};
         r_lpr        <= {LPR_W{1'b0}};
      end else if ((r_state == ST_IDLE) && start) begin
         r_ic_num     <= IC_Num;
         r_size       <= IRC_Size;
         r_start_addr <= input_start_address;
         r_lpr        <= w_lpr_calc;
      end else begin
         r_ic_num     <= r_ic_num;
         r_size       <= r_size;
         r_start_addr <= r_start_addr;
         r_lpr        <= r_lpr;
      end
   end

   // Word capture into the line and DRAM word counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_line     <= {LINE_W{1'b0}};
         r_word_cnt <= {ADDR_W{1'b0}};
         r_w        <= 2'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_word_cnt <= {ADDR_W{1'b0}};
                  r_w        <= 2'd0;
               end else begin
                  r_word_cnt <= r_word_cnt;
                  r_w        <= r_w;
               end
            end
            ST_RD: begin
               if (DRAM_ReadDone) begin
                  r_line[32'(r_w) * DRAM_W +: DRAM_W] <= DRAM_ReadData;
                  r_word_cnt <= r_word_cnt + ADDR_W'(1);
               end else begin
                  r_word_cnt <= r_word_cnt;
               end
            end
            ST_WINC: begin
               // Wraps 3 -> 0 naturally, ready for the next line
               r_w <= r_w + 2'd1;
            end
            default: begin
               r_line     <= r_line;
               r_word_cnt <= r_word_cnt;
               r_w        <= r_w;
            end
         endcase
      end
   end

   // Channel / row / line-in-row traversal and SRAM address
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ch        <= {CH_W{1'b0}};
         r_r         <= {SIZE_W{1'b0}};
         r_cl        <= {LPR_W{1'b0}};
         r_sram_addr <= {ADDR_W{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_ch        <= {CH_W{1'b0}};
                  r_r         <= {SIZE_W{1'b0}};
                  r_cl        <= {LPR_W{1'b0}};
                  r_sram_addr <= {ADDR_W{1'b0}};
               end else begin
                  r_ch        <= r_ch;
                  r_r         <= r_r;
                  r_cl        <= r_cl;
                  r_sram_addr <= r_sram_addr;
               end
            end
            ST_LINC: begin
               // One line holds 8 sixteen-bit elements
               r_sram_addr <= r_sram_addr + ADDR_W'(8);
               if (w_cl_last) begin
                  r_cl <= {LPR_W{1'b0}};
                  if (w_r_last) begin
                     r_r  <= {SIZE_W{1'b0}};
                     r_ch <= r_ch + CH_W'(1);
                  end else begin
                     r_r  <= r_r + SIZE_W'(1);
                     r_ch <= r_ch;
                  end
               end else begin
                  r_cl <= r_cl + LPR_W'(1);
                  r_r  <= r_r;
                  r_ch <= r_ch;
               end
            end
            default: begin
               r_ch        <= r_ch;
               r_r         <= r_r;
               r_cl        <= r_cl;
               r_sram_addr <= r_sram_addr;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_delta_controller_input_loader.sv
//------------------------------------------------------------------------------
// tb_delta_controller_input_loader
//
// Directed bench for the input loader. A responder process plays DRAM and
// SRAM (with programmable done-strobe latency), checks every read/write
// address and packed line against a simple model, and tracks output
// stability during stalls. Scenario results are compared through chk().
//------------------------------------------------------------------------------
module tb_delta_controller_input_loader;

   logic          clock;
   logic          reset;
   logic          start;
   logic [9:0]    IC_Num;
   logic [7:0]    IRC_Size;
   logic [31:0]   input_start_address;
   logic          DRAM_Read;
   logic [31:0]   DRAM_Address;
   logic [31:0]   DRAM_ReadData;
   logic          DRAM_ReadDone;
   logic [127:0]  Input_SRAM_w_d;
   logic [31:0]   Input_SRAM_w_addr;
   logic          Input_SRAM_w_en;
   logic          Input_SRAM_w_done;
   logic          busy;
   logic          finished;

   delta_controller_input_loader dut (
      .clock               (clock),
      .reset               (reset),
      .start               (start),
      .IC_Num              (IC_Num),
      .IRC_Size            (IRC_Size),
      .input_start_address (input_start_address),
      .DRAM_Read           (DRAM_Read),
      .DRAM_Address        (DRAM_Address),
      .DRAM_ReadData       (DRAM_ReadData),
      .DRAM_ReadDone       (DRAM_ReadDone),
      .Input_SRAM_w_d      (Input_SRAM_w_d),
      .Input_SRAM_w_addr   (Input_SRAM_w_addr),
      .Input_SRAM_w_en     (Input_SRAM_w_en),
      .Input_SRAM_w_done   (Input_SRAM_w_done),
      .busy                (busy),
      .finished            (finished)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int cyc = 0;
   int start_cyc = 0;

   // Responder configuration and bookkeeping
   int          rd_delay = 0;
   int          wr_delay = 0;
   int          rd_wait = 0;
   int          wr_wait = 0;
   logic [31:0] exp_base = 32'h0;
   int          n_reads = 0;
   int          n_writes = 0;
   int          rd_addr_err = 0;
   int          wr_err = 0;
   int          unstable = 0;
   int          rd_cycles = 0;
   int          wr_cycles = 0;
   int          fin_cnt = 0;
   int          fin_rel = -1;
   logic [31:0] first_rd_addr = 32'h0;
   logic [31:0] last_rd_addr = 32'h0;
   logic [31:0] first_wr_addr = 32'h0;
   logic [127:0] first_wd = 128'h0;
   logic [31:0] rd_hold = 32'h0;
   logic [31:0] wa_hold = 32'h0;
   logic [127:0] wd_hold = 128'h0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Data returned for the n-th word of a load
   function automatic logic [31:0] rd_data(input int n);
      if (n < 4) begin
         rd_data = 32'(32'h1111_1111 * (n + 1));
      end else begin
         rd_data = 32'hA500_0000 ^ 32'(n);
      end
   endfunction

   function automatic logic [127:0] exp_line(input int k);
      exp_line = {rd_data(4 * k + 3), rd_data(4 * k + 2), rd_data(4 * k + 1), rd_data(4 * k)};
   endfunction

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      forever begin
         @(posedge clock);
         cyc++;
      end
   end

   // DRAM / SRAM responder and monitor
   initial begin
      DRAM_ReadDone     = 1'b0;
      DRAM_ReadData     = 32'h0;
      Input_SRAM_w_done = 1'b0;
      forever begin
         @(negedge clock);
         if (finished) begin
            fin_cnt++;
            fin_rel = cyc - start_cyc;
         end
         if (DRAM_Read) rd_cycles++;
         if (Input_SRAM_w_en) wr_cycles++;
         if (!reset) begin
            DRAM_ReadDone     = 1'b0;
            Input_SRAM_w_done = 1'b0;
            rd_wait = 0;
            wr_wait = 0;
         end else begin
            if (DRAM_Read && !DRAM_ReadDone) begin
               if (rd_wait > 0 && DRAM_Address !== rd_hold) unstable++;
               rd_hold = DRAM_Address;
               if (rd_wait == rd_delay) begin
                  if (DRAM_Address !== exp_base + 32'(n_reads * 4)) rd_addr_err++;
                  if (n_reads == 0) first_rd_addr = DRAM_Address;
                  last_rd_addr  = DRAM_Address;
                  DRAM_ReadData = rd_data(n_reads);
                  DRAM_ReadDone = 1'b1;
                  n_reads++;
                  rd_wait = 0;
               end else begin
                  rd_wait++;
               end
            end else begin
               DRAM_ReadDone = 1'b0;
            end
            if (Input_SRAM_w_en && !Input_SRAM_w_done) begin
               if (wr_wait > 0 && (Input_SRAM_w_addr !== wa_hold || Input_SRAM_w_d !== wd_hold)) unstable++;
               wa_hold = Input_SRAM_w_addr;
               wd_hold = Input_SRAM_w_d;
               if (wr_wait == wr_delay) begin
                  if (Input_SRAM_w_addr !== 32'(n_writes * 8)) wr_err++;
                  if (Input_SRAM_w_d !== exp_line(n_writes)) wr_err++;
                  if (n_writes == 0) begin
                     first_wr_addr = Input_SRAM_w_addr;
                     first_wd      = Input_SRAM_w_d;
                  end
                  Input_SRAM_w_done = 1'b1;
                  n_writes++;
                  wr_wait = 0;
               end else begin
                  wr_wait++;
               end
            end else begin
               Input_SRAM_w_done = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clock);
      #2;
   endtask

   task automatic start_load(input logic [9:0] ic, input logic [7:0] sz, input logic [31:0] base);
      tick();
      IC_Num = ic;
      IRC_Size = sz;
      input_start_address = base;
      exp_base = base;
      n_reads = 0; n_writes = 0; rd_addr_err = 0; wr_err = 0; unstable = 0;
      rd_cycles = 0; wr_cycles = 0; fin_cnt = 0; fin_rel = -1;
      start = 1'b1;
      start_cyc = cyc;
      tick();
      start = 1'b0;
      // Scramble config to show it is latched
      IC_Num = 10'h3FF;
      IRC_Size = 8'hFF;
      input_start_address = 32'hDEAD_BEEF;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (fin_cnt > 0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk(tag, 128'(ok), 128'(1));
      for (int i = 0; i < 6; i++) tick();
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      IC_Num = 10'd0;
      IRC_Size = 8'd0;
      input_start_address = 32'h0;
      tick(); tick(); tick();

      // Reset state
      chk("rst_busy",   128'(busy), 128'(0));
      chk("rst_fin",    128'(finished), 128'(0));
      chk("rst_rd",     128'(DRAM_Read), 128'(0));
      chk("rst_wen",    128'(Input_SRAM_w_en), 128'(0));
      chk("rst_daddr",  128'(DRAM_Address), 128'(0));
      chk("rst_wd",     Input_SRAM_w_d, 128'(0));
      chk("rst_waddr",  128'(Input_SRAM_w_addr), 128'(0));
      reset = 1'b1;
      tick();

      // 8x8, one channel, immediate strobes
      rd_delay = 0; wr_delay = 0;
      start_load(10'd1, 8'd8, 32'h0000_1000);
      wait_done("t1_done", 200);
      chk("t1_reads",    128'(n_reads), 128'(32));
      chk("t1_writes",   128'(n_writes), 128'(8));
      chk("t1_first_ra", 128'(first_rd_addr), 128'(32'h0000_1000));
      chk("t1_last_ra",  128'(last_rd_addr), 128'(32'h0000_107C));
      chk("t1_ra_err",   128'(rd_addr_err), 128'(0));
      chk("t1_wr_err",   128'(wr_err), 128'(0));
      chk("t1_fin_cnt",  128'(fin_cnt), 128'(1));
      chk("t1_fin_cyc",  128'(fin_rel), 128'(90));
      chk("t1_busy",     128'(busy), 128'(0));
      chk("t1_pack",     first_wd, 128'h44444444_33333333_22222222_11111111);

      // Padded rows with stalls
      rd_delay = 3; wr_delay = 2;
      start_load(10'd2, 8'd10, 32'h0002_0000);
      wait_done("t2_done", 3000);
      chk("t2_reads",    128'(n_reads), 128'(160));
      chk("t2_writes",   128'(n_writes), 128'(40));
      chk("t2_last_ra",  128'(last_rd_addr), 128'(32'h0002_0000 + 32'd636));
      chk("t2_ra_err",   128'(rd_addr_err), 128'(0));
      chk("t2_wr_err",   128'(wr_err), 128'(0));
      chk("t2_stable",   128'(unstable), 128'(0));
      chk("t2_fin_cnt",  128'(fin_cnt), 128'(1));

      // Zero-size loads
      rd_delay = 0; wr_delay = 0;
      start_load(10'd3, 8'd0, 32'h0000_5000);
      wait_done("t3a_done", 20);
      chk("t3a_rd_cyc",  128'(rd_cycles), 128'(0));
      chk("t3a_wr_cyc",  128'(wr_cycles), 128'(0));
      chk("t3a_fin_cyc", 128'(fin_rel), 128'(2));
      start_load(10'd0, 8'd8, 32'h0000_5000);
      wait_done("t3b_done", 20);
      chk("t3b_rd_cyc",  128'(rd_cycles), 128'(0));
      chk("t3b_wr_cyc",  128'(wr_cycles), 128'(0));
      chk("t3b_fin_cyc", 128'(fin_rel), 128'(2));

      // Reset during a write stall, then restart
      wr_delay = 6;
      start_load(10'd1, 8'd8, 32'h0000_2000);
      for (int i = 0; i < 100; i++) begin
         if (Input_SRAM_w_en) break;
         tick();
      end
      chk("t4_wen_seen", 128'(Input_SRAM_w_en), 128'(1));
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("t4_wen_drop",  128'(Input_SRAM_w_en), 128'(0));
      chk("t4_rd_drop",   128'(DRAM_Read), 128'(0));
      chk("t4_busy_drop", 128'(busy), 128'(0));
      tick(); tick();
      reset = 1'b1;
      tick(); tick();
      chk("t4_idle_wen", 128'(wr_cycles > 0 ? Input_SRAM_w_en : 1'b0), 128'(0));
      wr_delay = 0;
      start_load(10'd1, 8'd8, 32'h0000_3000);
      wait_done("t4_done", 200);
      chk("t4_first_ra", 128'(first_rd_addr), 128'(32'h0000_3000));
      chk("t4_first_wa", 128'(first_wr_addr), 128'(0));
      chk("t4_writes",   128'(n_writes), 128'(8));
      chk("t4_wr_err",   128'(wr_err), 128'(0));
      chk("t4_fin_cyc",  128'(fin_rel), 128'(90));

      // start while busy is ignored
      start_load(10'd1, 8'd8, 32'h0000_4000);
      for (int i = 0; i < 20; i++) tick();
      IC_Num = 10'd1;
      IRC_Size = 8'd0;
      input_start_address = 32'h0000_9000;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("t5_done", 200);
      for (int i = 0; i < 15; i++) tick();
      chk("t5_fin_cnt",  128'(fin_cnt), 128'(1));
      chk("t5_reads",    128'(n_reads), 128'(32));
      chk("t5_writes",   128'(n_writes), 128'(8));
      chk("t5_ra_err",   128'(rd_addr_err), 128'(0));
      chk("t5_fin_cyc",  128'(fin_rel), 128'(90));
      chk("t5_busy",     128'(busy), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
